// File: rtl/sim_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sim_ctrl_pkg
// Description : Shared types and constants for the simulation control device:
//               FSM state encoding, default device addresses and the bit
//               positions of the console status word.
// Revision    : 1.0 - initial release
// ============================================================================
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [63:0] C_DEF_TOHOST_ADDR  = 64'h0000_0000_0000_1000;
  localparam logic [63:0] C_DEF_CONSOLE_ADDR = 64'h0000_0000_0000_1008;
  localparam logic [63:0] C_DEF_CYCLE_ADDR   = 64'h0000_0000_0000_1010;

  // Console status word returned on a load from the console address
  localparam int C_CON_STAT_FULL_BIT = 0;
  localparam int C_CON_STAT_OVF_BIT  = 1;

endpackage : sim_ctrl_pkg
`default_nettype wire

// File: rtl/sim_ctrl_dev_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO with a registered data output.
//               Pointers carry an extra wrap bit to tell full from empty.
//               A push while full is accepted only when a pop happens in the
//               same cycle; otherwise it is dropped and drop_o pulses.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               push_i, din_i - write request and data
//               pop_i         - consume the head entry (ignored when empty)
//               dout_o        - head entry (registered, 0 when empty)
//               full_o        - FIFO holds DEPTH entries
//               empty_o       - FIFO holds no entries
//               drop_o        - this cycle's push was discarded
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_dout;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic [AW:0]      w_wr_next;
  logic [AW:0]      w_rd_next;
  logic             w_empty_next;
  logic             w_head_is_new;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop  = pop_i && !w_empty;
  assign w_push = push_i && (!w_full || w_pop);

  assign w_wr_next    = r_wr_ptr + (AW+1)'(w_push);
  assign w_rd_next    = r_rd_ptr + (AW+1)'(w_pop);
  assign w_empty_next = (w_wr_next == w_rd_next);

  // The entry being written becomes the head only when the FIFO is left
  // holding just that entry; the array is not yet updated, so bypass it.
  assign w_head_is_new = w_push && (r_wr_ptr[AW-1:0] == w_rd_next[AW-1:0]);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      if (w_empty_next) begin
        r_dout <= '0;
      end else if (w_head_is_new) begin
        r_dout <= din_i;
      end else begin
        r_dout <= r_mem[w_rd_next[AW-1:0]];
      end
    end
  end

  assign dout_o  = r_dout;
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign drop_o  = push_i && w_full && !w_pop;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/sim_ctrl_dev.sv
`default_nettype none
// ============================================================================
// Module      : sim_ctrl_dev
// Description : Memory-mapped simulation control device. Captures the test
//               result written to TOHOST, buffers console bytes for the
//               testbench and runs a cycle counter with a timeout watchdog.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               mem_we_i/mem_re_i   - store / load strobes
//               mem_addr_i          - byte address (full 64-bit match)
//               mem_wdata_i         - store data
//               hit_o, mem_rdata_o  - combinational decode and load data
//               con_valid_o/con_data_o/con_ready_i - console byte stream
//               con_overflow_o      - sticky console drop flag
//               done_o, pass_o, timeout_o, fail_code_o - test result
//               cycle_cnt_o         - cycles spent in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module sim_ctrl_dev
  import sim_ctrl_pkg::*;
#(
  parameter logic [63:0] TOHOST_ADDR    = C_DEF_TOHOST_ADDR,
  parameter logic [63:0] CONSOLE_ADDR   = C_DEF_CONSOLE_ADDR,
  parameter logic [63:0] CYCLE_ADDR     = C_DEF_CYCLE_ADDR,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we_i,
  input  logic        mem_re_i,
  input  logic [63:0] mem_addr_i,
  input  logic [63:0] mem_wdata_i,
  output logic        hit_o,
  output logic [63:0] mem_rdata_o,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  input  logic        con_ready_i,
  output logic        con_overflow_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [62:0] fail_code_o,
  output logic [63:0] cycle_cnt_o
);

  localparam logic [63:0] C_LAST_CYCLE = 64'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_cycle;
  logic [62:0] r_code;
  logic        r_overflow;

  logic        w_hit_tohost;
  logic        w_hit_console;
  logic        w_hit_cycle;
  logic        w_tohost_st;
  logic        w_watchdog;
  logic        w_con_push;
  logic        w_con_full;
  logic        w_con_empty;
  logic        w_con_drop;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_hit_tohost  = (mem_addr_i == TOHOST_ADDR);
  assign w_hit_console = (mem_addr_i == CONSOLE_ADDR);
  assign w_hit_cycle   = (mem_addr_i == CYCLE_ADDR);
  assign hit_o         = w_hit_tohost || w_hit_console || w_hit_cycle;

  // Only stores with bit 0 set report a result; bit 0 clear is a no-op.
  assign w_tohost_st = mem_we_i && w_hit_tohost && mem_wdata_i[0] &&
                       (r_state == ST_RUN);
  assign w_watchdog  = (r_state == ST_RUN) && (r_cycle == C_LAST_CYCLE);
  assign w_con_push  = mem_we_i && w_hit_console;

  // --------------------------------------------------------------------------
  // Result FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        // A result store in the watchdog's last cycle takes priority.
        if (w_tohost_st) begin
          w_state_next = (mem_wdata_i[63:1] == 63'd0) ? ST_PASS : ST_FAIL;
        end else if (w_watchdog) begin
          w_state_next = ST_TIMEOUT;
        end
      end
      default: w_state_next = r_state;
    endcase
  end

  // --------------------------------------------------------------------------
  // Cycle counter and result code
  // --------------------------------------------------------------------------
  // The counter stops on the edge that leaves RUN, so it keeps showing the
  // value of the cycle in which the test ended.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= '0;
      r_code  <= '0;
    end else begin
      if ((r_state == ST_RUN) && (w_state_next == ST_RUN)) begin
        r_cycle <= r_cycle + 64'd1;
      end
      if (w_tohost_st) begin
        r_code <= mem_wdata_i[63:1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Console FIFO
  // --------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_con_push),
    .din_i   (mem_wdata_i[7:0]),
    .pop_i   (con_ready_i),
    .dout_o  (con_data_o),
    .full_o  (w_con_full),
    .empty_o (w_con_empty),
    .drop_o  (w_con_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_con_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Load data
  // --------------------------------------------------------------------------
  always_comb begin
    mem_rdata_o = 64'd0;
    if (mem_re_i) begin
      if (w_hit_cycle) begin
        mem_rdata_o = r_cycle;
      end else if (w_hit_console) begin
        mem_rdata_o[C_CON_STAT_FULL_BIT] = w_con_full;
        mem_rdata_o[C_CON_STAT_OVF_BIT]  = r_overflow;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign con_valid_o    = !w_con_empty;
  assign con_overflow_o = r_overflow;
  assign done_o         = (r_state != ST_RUN);
  assign pass_o         = (r_state == ST_PASS);
  assign timeout_o      = (r_state == ST_TIMEOUT);
  assign fail_code_o    = r_code;
  assign cycle_cnt_o    = r_cycle;

endmodule : sim_ctrl_dev
`default_nettype wire

// File: tb/tb_sim_ctrl_dev.sv
`default_nettype none
// ============================================================================
// Module      : tb_sim_ctrl_dev
// Description : Self-checking bench for sim_ctrl_dev: directed sequences for
//               the result FSM, watchdog and console FIFO, plus a table of
//               load/decode vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_ctrl_dev;

  localparam logic [63:0] C_TOHOST  = 64'h1000;
  localparam logic [63:0] C_CONSOLE = 64'h1008;
  localparam logic [63:0] C_CYCLE   = 64'h1010;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we_i;
  logic        mem_re_i;
  logic [63:0] mem_addr_i;
  logic [63:0] mem_wdata_i;
  logic        hit_o;
  logic [63:0] mem_rdata_o;
  logic        con_valid_o;
  logic [7:0]  con_data_o;
  logic        con_ready_i;
  logic        con_overflow_o;
  logic        done_o;
  logic        pass_o;
  logic        timeout_o;
  logic [62:0] fail_code_o;
  logic [63:0] cycle_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sim_ctrl_dev #(
    .TOHOST_ADDR    (C_TOHOST),
    .CONSOLE_ADDR   (C_CONSOLE),
    .CYCLE_ADDR     (C_CYCLE),
    .FIFO_DEPTH     (16),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_we_i       (mem_we_i),
    .mem_re_i       (mem_re_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .hit_o          (hit_o),
    .mem_rdata_o    (mem_rdata_o),
    .con_valid_o    (con_valid_o),
    .con_data_o     (con_data_o),
    .con_ready_i    (con_ready_i),
    .con_overflow_o (con_overflow_o),
    .done_o         (done_o),
    .pass_o         (pass_o),
    .timeout_o      (timeout_o),
    .fail_code_o    (fail_code_o),
    .cycle_cnt_o    (cycle_cnt_o)
  );

  typedef struct {
    logic        re;
    logic [63:0] addr;
    logic        exp_hit;
    logic [63:0] exp_rdata;
  } ld_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    mem_we_i    = 1'b0;
    mem_re_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    con_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic store(input logic [63:0] addr, input logic [63:0] data);
    mem_we_i    = 1'b1;
    mem_addr_i  = addr;
    mem_wdata_i = data;
    tick();
    mem_we_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    ld_vec_t     ld_tab [7];
    logic [7:0]  hi [3];
    logic [7:0]  drain_exp [17];

    // ---------------- watchdog with no stores ----------------
    do_reset();
    chk("rst_done",     64'(done_o), 64'd0);
    chk("rst_pass",     64'(pass_o), 64'd0);
    chk("rst_timeout",  64'(timeout_o), 64'd0);
    chk("rst_code",     64'(fail_code_o), 64'd0);
    chk("rst_cycle",    cycle_cnt_o, 64'd0);
    chk("rst_valid",    64'(con_valid_o), 64'd0);
    chk("rst_data",     64'(con_data_o), 64'd0);
    chk("rst_ovf",      64'(con_overflow_o), 64'd0);
    repeat (999) tick();
    chk("wd_c999_timeout", 64'(timeout_o), 64'd0);
    chk("wd_c999_cycle",   cycle_cnt_o, 64'd999);
    tick();
    chk("wd_timeout", 64'(timeout_o), 64'd1);
    chk("wd_done",    64'(done_o), 64'd1);
    chk("wd_pass",    64'(pass_o), 64'd0);
    chk("wd_cycle",   cycle_cnt_o, 64'd999);
    chk("wd_code",    64'(fail_code_o), 64'd0);
    repeat (5) tick();
    chk("wd_cycle_hold", cycle_cnt_o, 64'd999);

    // ---------------- pass at cycle 20 ----------------
    do_reset();
    repeat (20) tick();
    store(C_TOHOST, 64'h1);
    chk("pass_done",  64'(done_o), 64'd1);
    chk("pass_pass",  64'(pass_o), 64'd1);
    chk("pass_cycle", cycle_cnt_o, 64'd20);
    store(C_TOHOST, 64'h7);
    chk("pass_sticky", 64'(pass_o), 64'd1);
    chk("pass_code",   64'(fail_code_o), 64'd0);
    chk("pass_cycle_hold", cycle_cnt_o, 64'd20);

    // ---------------- fail code 3 ----------------
    do_reset();
    store(C_TOHOST, 64'h6);
    chk("fail_ignore_even", 64'(done_o), 64'd0);
    store(C_TOHOST, 64'h7);
    chk("fail_done",    64'(done_o), 64'd1);
    chk("fail_pass",    64'(pass_o), 64'd0);
    chk("fail_code",    64'(fail_code_o), 64'd3);
    chk("fail_timeout", 64'(timeout_o), 64'd0);

    // ---------------- console "Hi\n", ready high ----------------
    do_reset();
    hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;
    con_ready_i = 1'b1;
    mem_we_i    = 1'b1;
    mem_addr_i  = C_CONSOLE;
    for (int i = 0; i < 3; i++) begin
      mem_wdata_i = 64'(hi[i]);
      tick();
      if (i == 2) mem_we_i = 1'b0;
      chk($sformatf("hi_valid%0d", i), 64'(con_valid_o), 64'd1);
      chk($sformatf("hi_data%0d", i),  64'(con_data_o), 64'(hi[i]));
    end
    tick();
    chk("hi_empty", 64'(con_valid_o), 64'd0);

    // ---------------- overflow, loads, drain ----------------
    do_reset();
    mem_we_i   = 1'b1;
    mem_addr_i = C_CONSOLE;
    for (int i = 0; i < 17; i++) begin
      mem_wdata_i = 64'h30 + 64'(i);
      tick();
    end
    mem_we_i = 1'b0;
    chk("ovf_flag",  64'(con_overflow_o), 64'd1);
    chk("ovf_valid", 64'(con_valid_o), 64'd1);
    chk("ovf_head",  64'(con_data_o), 64'h30);
    tick();
    chk("ovf_head_stable", 64'(con_data_o), 64'h30);

    // cycle counter now reads 18 (17 pushes plus one hold cycle)
    ld_tab[0] = '{re: 1'b1, addr: C_CONSOLE,            exp_hit: 1'b1, exp_rdata: 64'd3};
    ld_tab[1] = '{re: 1'b0, addr: C_CONSOLE,            exp_hit: 1'b1, exp_rdata: 64'd0};
    ld_tab[2] = '{re: 1'b1, addr: C_CYCLE,              exp_hit: 1'b1, exp_rdata: 64'd18};
    ld_tab[3] = '{re: 1'b1, addr: C_TOHOST,             exp_hit: 1'b1, exp_rdata: 64'd0};
    ld_tab[4] = '{re: 1'b1, addr: 64'h1004,             exp_hit: 1'b0, exp_rdata: 64'd0};
    ld_tab[5] = '{re: 1'b1, addr: 64'h1_0000_1000,      exp_hit: 1'b0, exp_rdata: 64'd0};
    ld_tab[6] = '{re: 1'b1, addr: 64'h1018,             exp_hit: 1'b0, exp_rdata: 64'd0};
    for (int i = 0; i < 7; i++) begin
      mem_re_i   = ld_tab[i].re;
      mem_addr_i = ld_tab[i].addr;
      #1;
      chk($sformatf("ld%0d_hit", i),   64'(hit_o), 64'(ld_tab[i].exp_hit));
      chk($sformatf("ld%0d_rdata", i), mem_rdata_o, ld_tab[i].exp_rdata);
    end
    mem_re_i = 1'b0;
    tick();
    chk("ld_no_side_effect", 64'(con_data_o), 64'h30);

    // Drain, pushing 0x55 in the first cycle while still full.
    for (int i = 0; i < 16; i++) drain_exp[i] = 8'h30 + 8'(i);
    drain_exp[16] = 8'h55;
    con_ready_i = 1'b1;
    mem_we_i    = 1'b1;
    mem_addr_i  = C_CONSOLE;
    mem_wdata_i = 64'h55;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("drain_valid%0d", i), 64'(con_valid_o), 64'd1);
      chk($sformatf("drain_data%0d", i),  64'(con_data_o), 64'(drain_exp[i]));
      tick();
      mem_we_i = 1'b0;
    end
    chk("drain_empty", 64'(con_valid_o), 64'd0);

    // ---------------- reset mid-operation ----------------
    con_ready_i = 1'b0;
    store(C_CONSOLE, 64'hAA);
    store(C_CONSOLE, 64'hBB);
    chk("mid_valid_before", 64'(con_valid_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", 64'(con_valid_o), 64'd0);
    chk("mid_data",  64'(con_data_o), 64'd0);
    chk("mid_ovf",   64'(con_overflow_o), 64'd0);
    chk("mid_cycle", cycle_cnt_o, 64'd0);
    chk("mid_done",  64'(done_o), 64'd0);

    // ---------------- store and watchdog in the same cycle ----------------
    do_reset();
    repeat (999) tick();
    chk("race_cycle", cycle_cnt_o, 64'd999);
    store(C_TOHOST, 64'h1);
    chk("race_pass",    64'(pass_o), 64'd1);
    chk("race_timeout", 64'(timeout_o), 64'd0);
    chk("race_done",    64'(done_o), 64'd1);
    chk("race_cycle_hold", cycle_cnt_o, 64'd999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_sim_ctrl_dev
`default_nettype wire
